// File: rtl/sync_ram_2p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sync_ram_2p                                                   |
// | Purpose  : Simple dual-port synchronous RAM. One write port with per-lane|
// |            byte/nibble enables, one read port with 1- or 2-cycle read    |
// |            latency, selectable read-during-write behaviour and a         |
// |            post-reset zeroing sweep of the whole array.                  |
// |                                                                          |
// | Ports    : clk        - single clock, rising edge                        |
// |            rst_n      - asynchronous active-low reset                    |
// |            wr_en      - write request                                    |
// |            wr_addr_i  - write address                                    |
// |            wr_data    - write data                                       |
// |            wr_be      - lane enables, bit i covers lane i of wr_data     |
// |            rd_en      - read request                                     |
// |            rd_addr_i  - read address                                     |
// |            rd_data    - read data, held while rd_valid is low            |
// |            rd_valid   - one-cycle strobe per accepted read               |
// |            init_done  - array cleared and ready for traffic              |
// |                                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sync_ram_2p #(
   parameter int DATA_WIDTH     = 8,
   parameter int LANE_WIDTH     = 4,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = 4,
   parameter int RD_LATENCY     = 1,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int NUM_LANES     = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_LANES-1:0]  wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  init_done
);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // One extra bit so DEPTH == 2^ADDR_WIDTH is representable in the compare.
   localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] c_last_adr = ADDR_WIDTH'(DEPTH - 1);

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic                  r_init_done;

   logic                  r_s1_valid;
   logic [DATA_WIDTH-1:0] r_s1_data;

   logic                  w_wr_in_range;
   logic                  w_rd_in_range;
   logic                  w_wr_go;
   logic                  w_rd_go;
   logic                  w_clr_go;
   logic [DATA_WIDTH-1:0] w_rd_raw;
   logic [DATA_WIDTH-1:0] w_rd_word;

   assign w_wr_in_range = ({1'b0, wr_addr_i} < c_depth);
   assign w_rd_in_range = ({1'b0, rd_addr_i} < c_depth);

   // rst_n gates the array updates so a clock running during reset cannot
   // modify memory contents; the control registers are held by the async
   // reset anyway.
   assign w_clr_go = rst_n && (r_state == ST_INIT);
   assign w_wr_go  = rst_n && (r_state == ST_READY) && wr_en && w_wr_in_range;
   assign w_rd_go  = (r_state == ST_READY) && rd_en;

   // Out-of-range reads still produce a strobe, carrying zero data.
   assign w_rd_raw = w_rd_in_range ? r_mem[rd_addr_i] : '0;

   // ------------------------------------------------------------------------
   // Read-during-write policy. With write-first, lanes being written on the
   // same edge to the same address are forwarded from wr_data; untouched
   // lanes keep the stored value. Read-first simply returns the stored word,
   // which is the pre-write value because the array updates on the edge.
   // ------------------------------------------------------------------------
   generate
      if (WRITE_FIRST != 0) begin : g_write_first
         logic w_collide;
         assign w_collide = w_wr_go && w_rd_go && (wr_addr_i == rd_addr_i);

         for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign w_rd_word[l*LANE_WIDTH +: LANE_WIDTH] =
               (w_collide && wr_be[l]) ? wr_data[l*LANE_WIDTH +: LANE_WIDTH]
                                       : w_rd_raw[l*LANE_WIDTH +: LANE_WIDTH];
         end
      end else begin : g_read_first
         assign w_rd_word = w_rd_raw;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Array write port. The clear sweep owns the array while in INIT; user
   // writes are only honoured in READY and only for enabled lanes.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_clr_go) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_go) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_be[l]) begin
               r_mem[wr_addr_i][l*LANE_WIDTH +: LANE_WIDTH] <=
                  wr_data[l*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM: INIT sweeps one word per cycle, READY serves traffic.
   // init_done is registered, so it rises the cycle after the last clear
   // write, i.e. exactly DEPTH edges after reset release.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
         r_clr_cnt   <= '0;
         r_init_done <= (CLEAR_ON_RESET == 0);
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_clr_cnt == c_last_adr) begin
                  r_state     <= ST_READY;
                  r_init_done <= 1'b1;
                  r_clr_cnt   <= '0;
               end else begin
                  r_clr_cnt   <= r_clr_cnt + 1'b1;
               end
            end
            ST_READY: begin
               r_init_done <= 1'b1;
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign init_done = r_init_done;

   // ------------------------------------------------------------------------
   // Read pipeline, first stage. Data only moves on an accepted read so the
   // output holds its last value between strobes.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_rd_go;
         if (w_rd_go) begin
            r_s1_data <= w_rd_word;
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  r_s2_valid;
         logic [DATA_WIDTH-1:0] r_s2_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_data <= r_s1_data;
               end
            end
         end

         assign rd_valid = r_s2_valid;
         assign rd_data  = r_s2_data;
      end else begin : g_lat1
         assign rd_valid = r_s1_valid;
         assign rd_data  = r_s1_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_2p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sync_ram_2p                                                |
// | Purpose  : Self-checking bench for sync_ram_2p. Three instances share    |
// |            one stimulus stream: A = defaults (latency 1, read-first),    |
// |            B = latency 2 / write-first, C = DEPTH 12. Each is compared   |
// |            against a word-level reference memory kept here.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sync_ram_2p;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic       rd_en;
   logic [3:0] wr_addr;
   logic [3:0] rd_addr;
   logic [7:0] wr_data;
   logic [1:0] wr_be;

   logic [7:0] rd_data_a, rd_data_b, rd_data_c;
   logic       rd_valid_a, rd_valid_b, rd_valid_c;
   logic       init_done_a, init_done_b, init_done_c;

   int total = 0;
   int bad   = 0;

   sync_ram_2p #(.RD_LATENCY(1), .WRITE_FIRST(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr_i(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr_i(rd_addr),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_done(init_done_a));

   sync_ram_2p #(.RD_LATENCY(2), .WRITE_FIRST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr_i(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr_i(rd_addr),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_done(init_done_b));

   sync_ram_2p #(.DEPTH(12), .RD_LATENCY(1), .WRITE_FIRST(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr_i(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr_i(rd_addr),
      .rd_data(rd_data_c), .rd_valid(rd_valid_c), .init_done(init_done_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Reference model: per-instance word array plus expected output values.
   // ------------------------------------------------------------------------
   int         depth_c [3] = '{16, 16, 12};
   int         lat_c   [3] = '{1, 2, 1};
   bit         wf_c    [3] = '{1'b0, 1'b1, 1'b0};
   logic [7:0] mem_m   [3][16];
   int         edges;
   logic [7:0] exp_data   [3];
   logic       exp_valid  [3];
   logic       exp_done   [3];
   logic [7:0] pend_data  [3];
   logic       pend_valid [3];

   function automatic logic [9:0] obs(int c);
      case (c)
         0:       return {init_done_a, rd_valid_a, rd_data_a};
         1:       return {init_done_b, rd_valid_b, rd_data_b};
         default: return {init_done_c, rd_valid_c, rd_data_c};
      endcase
   endfunction

   function automatic logic [9:0] expv(int c);
      return {exp_done[c], exp_valid[c], exp_data[c]};
   endfunction

   // The array is usable (all zero) once the sweep has run; nothing can be
   // read before then, so the model treats it as zero from reset onward.
   task automatic model_reset();
      edges = 0;
      for (int c = 0; c < 3; c++) begin
         exp_data[c]   = 8'h00;
         exp_valid[c]  = 1'b0;
         exp_done[c]   = 1'b0;
         pend_data[c]  = 8'h00;
         pend_valid[c] = 1'b0;
         for (int a = 0; a < 16; a++) mem_m[c][a] = 8'h00;
      end
   endtask

   // Advance one clock edge and update the expected outputs from the inputs
   // presented at that edge. Returns 1 ns after the edge.
   task automatic step();
      logic [7:0] old_w, new_w, rv;
      logic       acc;
      @(posedge clk);
      if (rst_n) begin
         edges++;
         for (int c = 0; c < 3; c++) begin
            acc = 1'b0;
            rv  = 8'h00;
            if (edges > depth_c[c]) begin
               old_w = mem_m[c][wr_addr];
               new_w = old_w;
               for (int l = 0; l < 2; l++)
                  if (wr_be[l]) new_w[l*4 +: 4] = wr_data[l*4 +: 4];
               if (rd_en) begin
                  acc = 1'b1;
                  if (int'(rd_addr) < depth_c[c])
                     rv = (wf_c[c] && wr_en && wr_addr == rd_addr) ? new_w
                                                                    : mem_m[c][rd_addr];
               end
               if (wr_en && int'(wr_addr) < depth_c[c]) mem_m[c][wr_addr] = new_w;
            end
            if (lat_c[c] == 1) begin
               exp_valid[c] = acc;
               if (acc) exp_data[c] = rv;
            end else begin
               exp_valid[c] = pend_valid[c];
               if (pend_valid[c]) exp_data[c] = pend_data[c];
               pend_valid[c] = acc;
               pend_data[c]  = rv;
            end
            exp_done[c] = (edges >= depth_c[c]);
         end
      end
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; wr_addr = 4'h0; rd_addr = 4'h0;
      wr_data = 8'h00; wr_be = 2'b00;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      idle();
      rd_en = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (obs(c) !== 10'h000) begin
            bad++;
            $display("FAIL reset_state dut%0d: actual=%h required=%h", c, obs(c), 10'h000);
         end
      end
      #2 rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         total++;
         if (init_done_a !== (i == 16) || rd_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL sweep edge %0d: actual done=%b valid=%b required done=%b valid=0",
                     i, init_done_a, rd_valid_a, (i == 16));
         end
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL sweep[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         step();
         total++;
         if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin
            bad++;
            $display("FAIL cleared addr %0d: actual valid=%b data=%h required valid=1 data=00",
                     i, rd_valid_a, rd_data_a);
         end
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL clear_read[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      idle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_fill_readback();
      int first_a = -1, first_b = -1, nb = 0;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(8'h40 + i); wr_be = 2'b11;
         step();
      end
      idle();
      for (int i = 0; i < 18; i++) begin
         rd_en   = (i < 16);
         rd_addr = 4'(i);
         step();
         if (rd_valid_a && first_a < 0) first_a = i;
         if (rd_valid_b && first_b < 0) first_b = i;
         if (rd_valid_b) begin
            total++;
            if (rd_data_b !== 8'(8'h40 + nb)) begin
               bad++;
               $display("FAIL fill_lat2 #%0d: actual=%h required=%h", nb, rd_data_b, 8'(8'h40 + nb));
            end
            nb++;
         end
         if (i < 16) begin
            total++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== 8'(8'h40 + i)) begin
               bad++;
               $display("FAIL fill_lat1 addr %0d: actual valid=%b data=%h required valid=1 data=%h",
                        i, rd_valid_a, rd_data_a, 8'(8'h40 + i));
            end
         end
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL fill[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      total++;
      if (first_a !== 0 || first_b !== 1 || nb !== 16) begin
         bad++;
         $display("FAIL fill_latency: actual first_a=%0d first_b=%0d count_b=%0d required 0 1 16",
                  first_a, first_b, nb);
      end
      idle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_lanes();
      // {wr_en, wr_data, wr_be, rd_en} per cycle, all on address 3
      logic [11:0] tbl [7] = '{
         {1'b1, 8'hA5, 2'b11, 1'b0},
         {1'b1, 8'h3C, 2'b01, 1'b0},
         {1'b0, 8'h00, 2'b00, 1'b1},
         {1'b1, 8'hFF, 2'b00, 1'b0},
         {1'b0, 8'h00, 2'b00, 1'b1},
         {1'b0, 8'h00, 2'b00, 1'b0},
         {1'b0, 8'h00, 2'b00, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         {wr_en, wr_data, wr_be, rd_en} = tbl[i];
         wr_addr = 4'd3; rd_addr = 4'd3;
         step();
         if (i == 2 || i == 4) begin
            total++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== 8'hAC) begin
               bad++;
               $display("FAIL lanes step %0d: actual valid=%b data=%h required valid=1 data=ac",
                        i, rd_valid_a, rd_data_a);
            end
         end
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL lanes[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      idle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_collision();
      // {wr_en, wr_data, wr_be, rd_en} per cycle, all on address 5
      logic [11:0] tbl [5] = '{
         {1'b1, 8'h11, 2'b11, 1'b0},
         {1'b1, 8'h22, 2'b11, 1'b1},
         {1'b1, 8'h9F, 2'b10, 1'b1},
         {1'b0, 8'h00, 2'b00, 1'b0},
         {1'b0, 8'h00, 2'b00, 1'b0}};
      for (int i = 0; i < 5; i++) begin
         {wr_en, wr_data, wr_be, rd_en} = tbl[i];
         wr_addr = 4'd5; rd_addr = 4'd5;
         step();
         if (i == 1) begin
            total++;
            if (rd_data_a !== 8'h11 || rd_data_c !== 8'h11) begin
               bad++;
               $display("FAIL collision_read_first: actual a=%h c=%h required 11", rd_data_a, rd_data_c);
            end
         end
         if (i == 2) begin
            total++;
            if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h22) begin
               bad++;
               $display("FAIL collision_write_first: actual valid=%b data=%h required valid=1 data=22",
                        rd_valid_b, rd_data_b);
            end
         end
         if (i == 3) begin
            total++;
            if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h92) begin
               bad++;
               $display("FAIL collision_merge: actual valid=%b data=%h required valid=1 data=92",
                        rd_valid_b, rd_data_b);
            end
         end
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL collision[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      idle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_out_of_range();
      // {wr_en, wr_addr, rd_en, rd_addr}
      logic [9:0] tbl [4] = '{
         {1'b1, 4'd13, 1'b0, 4'd0},
         {1'b0, 4'd0,  1'b1, 4'd13},
         {1'b0, 4'd0,  1'b1, 4'd11},
         {1'b0, 4'd0,  1'b0, 4'd0}};
      for (int i = 0; i < 4; i++) begin
         {wr_en, wr_addr, rd_en, rd_addr} = tbl[i];
         wr_data = 8'hFF; wr_be = 2'b11;
         step();
         if (i == 1) begin
            total++;
            if (rd_valid_c !== 1'b1 || rd_data_c !== 8'h00) begin
               bad++;
               $display("FAIL oor_read13: actual valid=%b data=%h required valid=1 data=00",
                        rd_valid_c, rd_data_c);
            end
         end
         if (i == 2) begin
            total++;
            if (rd_valid_c !== 1'b1 || rd_data_c !== 8'h4B) begin
               bad++;
               $display("FAIL oor_read11: actual valid=%b data=%h required valid=1 data=4b",
                        rd_valid_c, rd_data_c);
            end
         end
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL oor[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      idle();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         rd_en   = 1'($urandom_range(0, 1));
         wr_addr = 4'($urandom_range(0, 15));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         wr_data = 8'($urandom);
         wr_be   = 2'($urandom_range(0, 3));
         step();
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL random[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      idle();
      step();
      step();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid();
      int b_pulses = 0;
      int done_at  = -1;
      rd_en = 1'b1; rd_addr = 4'd2;
      step();
      rd_en = 1'b0;
      for (int r = 0; r < 2; r++) begin
         #2 rst_n = 1'b0;
         model_reset();
         #1;
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL midreset_assert%0d dut%0d: actual=%h required=%h", r, c, obs(c), expv(c));
            end
         end
         step();
         if (rd_valid_b) b_pulses++;
         #2 rst_n = 1'b1;
         if (r == 0) begin
            for (int i = 0; i < 7; i++) begin
               step();
               if (rd_valid_b) b_pulses++;
               for (int c = 0; c < 3; c++) begin
                  total++;
                  if (obs(c) !== expv(c)) begin
                     bad++;
                     $display("FAIL midsweep[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
                  end
               end
            end
         end
      end
      for (int i = 1; i <= 20; i++) begin
         step();
         if (rd_valid_b) b_pulses++;
         if (init_done_a && done_at < 0) done_at = i;
         for (int c = 0; c < 3; c++) begin
            total++;
            if (obs(c) !== expv(c)) begin
               bad++;
               $display("FAIL resweep[%0d] dut%0d: actual=%h required=%h", i, c, obs(c), expv(c));
            end
         end
      end
      total++;
      if (done_at !== 16 || b_pulses !== 0) begin
         bad++;
         $display("FAIL midreset_summary: actual done_at=%0d b_pulses=%0d required 16 0",
                  done_at, b_pulses);
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b1;
      model_reset();
      test_reset();
      test_fill_readback();
      test_lanes();
      test_collision();
      test_out_of_range();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
